// File: rtl/display_pkg.sv
// Shared definitions for the display pager: segment codes, FSM states and
// the decimal digit count needed for a given value width.
package display_pkg;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [6:0] SEG_C_LOWER = 7'h27;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } fsm_t;

    // Decimal digits needed to show 2**data_w - 1.
    function automatic int unsigned bcd_digits(input int unsigned data_w);
        if (data_w <= 3) return 1;
        if (data_w <= 6) return 2;
        if (data_w <= 9) return 3;
        return 4;
    endfunction

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex digit to active-low seven-segment decoder (bit6=g .. bit0=a).
// Ports: digit - 4-bit value 0..F; seg_c - active-low segment pattern.
module seg7_hex (
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = 7'h7F;
        case (digit)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            default: seg_c = 7'h0E;
        endcase
    end

endmodule

// File: rtl/display_pager.sv
// Paged status display: shows one of N_CH channel values in decimal on
// HEX3..HEX0 with a "c<page>" label on HEX5..HEX4, pages by button or timer,
// blinks while halted and stretches the match indication on LEDR[3].
// Ports: clk, resetn (async active-low); ch_data - packed channel values;
// state, halt_signal, match_signal - core status; page_next - advance pulse;
// auto_page - timer paging enable; HEX0..HEX5 - active-low segments;
// LEDR - status LEDs; conv_busy - BCD conversion in progress.
module display_pager
    import display_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned N_CH        = 4,
    parameter int unsigned PAGE_TICKS  = 50_000_000,
    parameter int unsigned BLINK_TICKS = 25_000_000,
    parameter int unsigned MATCH_HOLD  = 12_500_000,
    parameter int unsigned TC_CH       = N_CH - 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic [1:0]               state,
    input  logic                     halt_signal,
    input  logic                     match_signal,
    input  logic                     page_next,
    input  logic                     auto_page,
    output logic [6:0]               HEX0,
    output logic [6:0]               HEX1,
    output logic [6:0]               HEX2,
    output logic [6:0]               HEX3,
    output logic [6:0]               HEX4,
    output logic [6:0]               HEX5,
    output logic [9:0]               LEDR,
    output logic                     conv_busy
);

    localparam int unsigned ND    = bcd_digits(DATA_W);
    localparam int unsigned BCD_W = 4 * ND;
    localparam int unsigned CW    = $clog2(DATA_W + 1);
    localparam int unsigned PW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TW    = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
    localparam int unsigned BW    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned MW    = (MATCH_HOLD > 1) ? $clog2(MATCH_HOLD) : 1;

    fsm_t              fsm_q, fsm_d;
    logic [DATA_W-1:0] ch_sel, sample_q, shreg_q;
    logic [BCD_W-1:0]  bcd_q, bcd_adj, bcd_shift;
    logic [CW-1:0]     bit_cnt_q;
    logic [PW-1:0]     page_q, page_loaded_q;
    logic [15:0]       digits_q;
    logic              lit_q;
    logic [TW-1:0]     tick_q;
    logic              tick_hit;
    logic [BW-1:0]     blink_cnt_q;
    logic              blink_phase_q;
    logic [MW-1:0]     hold_q;
    logic              match_prev_q;
    logic [6:0]        seg0_c, seg1_c, seg2_c, seg3_c, seg4_c;
    logic              blank_all, d3z, d2z, d1z;

    // Value of the currently selected channel.
    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (page_q == PW'(k)) ch_sel = ch_data[k*DATA_W +: DATA_W];
        end
    end

    // One shift-add-3 step: correct nibbles >= 5, then shift in the next sample bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < ND; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
        end
        bcd_shift = (bcd_adj << 1) | BCD_W'(shreg_q[DATA_W-1]);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fsm_q <= LOAD;
        else         fsm_q <= fsm_d;
    end

    // FSM next state; SHOW reloads on a data change or a page change since LOAD.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            LOAD: fsm_d = CONV;
            CONV: if (bit_cnt_q == CW'(1)) fsm_d = SHOW;
            SHOW: if ((ch_sel != sample_q) || (page_q != page_loaded_q)) fsm_d = LOAD;
            default: fsm_d = LOAD;
        endcase
    end

    // Conversion datapath; digit registers update only on the final CONV step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_q      <= '0;
            shreg_q       <= '0;
            bcd_q         <= '0;
            bit_cnt_q     <= '0;
            page_loaded_q <= '0;
            digits_q      <= '0;
            lit_q         <= 1'b0;
            conv_busy     <= 1'b0;
        end else begin
            conv_busy <= (fsm_d != SHOW);
            case (fsm_q)
                LOAD: begin
                    sample_q      <= ch_sel;
                    shreg_q       <= ch_sel;
                    bcd_q         <= '0;
                    bit_cnt_q     <= CW'(DATA_W);
                    page_loaded_q <= page_q;
                end
                CONV: begin
                    bcd_q     <= bcd_shift;
                    shreg_q   <= shreg_q << 1;
                    bit_cnt_q <= bit_cnt_q - CW'(1);
                    if (bit_cnt_q == CW'(1)) begin
                        digits_q <= 16'(bcd_shift);
                        lit_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tick_hit = auto_page && (tick_q == TW'(PAGE_TICKS - 1));

    // Page select; a button press and a timer tick together advance once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            page_q <= '0;
            tick_q <= '0;
        end else begin
            if (!auto_page || page_next || tick_hit) tick_q <= '0;
            else                                     tick_q <= tick_q + TW'(1);
            if (page_next || tick_hit) begin
                page_q <= (page_q == PW'(N_CH - 1)) ? '0 : page_q + PW'(1);
            end
        end
    end

    // Halt blink phase; leaving halt restores the lit phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (!halt_signal) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + BW'(1);
        end
    end

    // Match stretch and status LEDs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_q       <= '0;
            match_prev_q <= 1'b0;
            LEDR         <= '0;
        end else begin
            match_prev_q <= match_signal;
            if (match_signal && !match_prev_q) hold_q <= MW'(MATCH_HOLD - 1);
            else if (hold_q != '0)             hold_q <= hold_q - MW'(1);
            LEDR <= {6'(ch_data[TC_CH*DATA_W +: DATA_W]),
                     (hold_q != '0) || match_signal, halt_signal, state};
        end
    end

    seg7_hex u_seg0 (.digit(digits_q[3:0]),   .seg_c(seg0_c));
    seg7_hex u_seg1 (.digit(digits_q[7:4]),   .seg_c(seg1_c));
    seg7_hex u_seg2 (.digit(digits_q[11:8]),  .seg_c(seg2_c));
    seg7_hex u_seg3 (.digit(digits_q[15:12]), .seg_c(seg3_c));
    seg7_hex u_seg4 (.digit(4'(page_q)),      .seg_c(seg4_c));

    // Leading-zero blanking and the blank override (before first value, or blink).
    always_comb begin
        blank_all = !lit_q || blink_phase_q;
        d3z  = (digits_q[15:12] == 4'd0);
        d2z  = d3z && (digits_q[11:8] == 4'd0);
        d1z  = d2z && (digits_q[7:4] == 4'd0);
        HEX0 = blank_all         ? SEG_BLANK : seg0_c;
        HEX1 = (blank_all || d1z) ? SEG_BLANK : seg1_c;
        HEX2 = (blank_all || d2z) ? SEG_BLANK : seg2_c;
        HEX3 = (blank_all || d3z) ? SEG_BLANK : seg3_c;
        HEX4 = blank_all         ? SEG_BLANK : seg4_c;
        HEX5 = blank_all         ? SEG_BLANK : SEG_C_LOWER;
    end

endmodule

// File: tb/tb_display_pager.sv
// Directed bench for display_pager with a display scoreboard and per-cycle checks.
module tb_display_pager;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] ch_data;
    logic [1:0]  state;
    logic        halt_signal, match_signal, page_next, auto_page;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0]  LEDR;
    logic        conv_busy;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [41:0] disp;
    } exp_t;
    exp_t sb_q[$];

    display_pager #(
        .DATA_W(8), .N_CH(4), .PAGE_TICKS(8), .BLINK_TICKS(4), .MATCH_HOLD(6), .TC_CH(3)
    ) dut (
        .clk(clk), .resetn(resetn), .ch_data(ch_data), .state(state),
        .halt_signal(halt_signal), .match_signal(match_signal),
        .page_next(page_next), .auto_page(auto_page),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .LEDR(LEDR), .conv_busy(conv_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Expected {HEX5,HEX4,HEX3,HEX2,HEX1,HEX0} for a value on a page.
    function automatic logic [41:0] disp_ref(input int v, input int pg);
        logic [6:0] h3, h2, h1, h0;
        h0 = seg_ref(v % 10);
        h1 = (v >= 10)   ? seg_ref((v / 10) % 10)   : 7'h7F;
        h2 = (v >= 100)  ? seg_ref((v / 100) % 10)  : 7'h7F;
        h3 = (v >= 1000) ? seg_ref((v / 1000) % 10) : 7'h7F;
        return {7'h27, seg_ref(pg), h3, h2, h1, h0};
    endfunction

    function automatic logic [41:0] disp_obs();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int v, input int pg);
        exp_t e;
        e.tag  = tag;
        e.disp = disp_ref(v, pg);
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_underflow: observed=empty expected=entry");
        end else begin
            e = sb_q.pop_front();
            check(e.tag, 64'(disp_obs()), 64'(e.disp));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vals [4];
        int busy_cnt;
        logic held;
        logic [41:0] exp_disp;

        vals = '{75, 60, 10, 0};
        resetn = 1'b0; ch_data = {8'd0, 8'd10, 8'd60, 8'd50}; state = 2'd0;
        halt_signal = 1'b0; match_signal = 1'b0; page_next = 1'b0; auto_page = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_hex", 64'(disp_obs()), 64'({6{7'h7F}}));
        check("rst_ledr", 64'(LEDR), 64'd0);
        check("rst_busy", 64'(conv_busy), 64'd0);

        // First conversion after release
        resetn = 1'b1;
        push_exp("disp_ch0_50", 50, 0);
        repeat (10) cyc();
        pop_check();
        check("ledr_idle", 64'(LEDR), 64'd0);

        // Data change in SHOW: 10-cycle latency, 9 busy cycles, old digits held
        ch_data[7:0] = 8'd75;
        push_exp("disp_ch0_75", 75, 0);
        busy_cnt = 0;
        held = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (conv_busy) busy_cnt++;
            if (i < 10 && {HEX1, HEX0} !== {7'h12, 7'h40}) held = 1'b0;
            if (i == 10) pop_check();
        end
        check("busy_cycles", 64'(busy_cnt), 64'd9);
        check("digits_held", 64'(held), 64'd1);

        // Manual paging with wrap
        for (int p = 1; p <= 4; p++) begin
            page_next = 1'b1;
            cyc();
            page_next = 1'b0;
            check($sformatf("hex4_page%0d", p % 4), 64'(HEX4), 64'(seg_ref(p % 4)));
            push_exp($sformatf("disp_page%0d", p % 4), vals[p % 4], p % 4);
            repeat (11) cyc();
            pop_check();
        end

        // Auto paging coinciding with page_next gives one advance, then 8 cycles to the next
        auto_page = 1'b1;
        repeat (7) cyc();
        page_next = 1'b1;
        cyc();
        page_next = 1'b0;
        check("auto_coincide", 64'(HEX4), 64'(seg_ref(1)));
        repeat (7) cyc();
        check("auto_hold7", 64'(HEX4), 64'(seg_ref(1)));
        cyc();
        check("auto_next", 64'(HEX4), 64'(seg_ref(2)));
        auto_page = 1'b0;
        push_exp("disp_page2_auto", 10, 2);
        repeat (24) cyc();
        pop_check();

        // Match stretch with a retrigger three cycles after the first pulse
        for (int i = 1; i <= 12; i++) begin
            match_signal = (i == 1 || i == 4);
            cyc();
            check($sformatf("match_led_c%0d", i), 64'(LEDR[3]), 64'(i <= 9));
        end
        match_signal = 1'b0;

        // Halt blink: lit 4, blank 4, ...
        halt_signal = 1'b1;
        state = 2'd3;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            exp_disp = (((i / 4) % 2) == 1) ? {6{7'h7F}} : disp_ref(10, 2);
            check($sformatf("halt_c%0d", i), 64'({disp_obs(), LEDR[2:0]}), 64'({exp_disp, 3'b111}));
        end
        halt_signal = 1'b0;
        state = 2'd0;
        cyc();
        check("halt_release", 64'(disp_obs()), 64'(disp_ref(10, 2)));

        // Asynchronous reset in the middle of a conversion
        ch_data[23:16] = 8'd99;
        repeat (4) cyc();
        check("busy_mid_conv", 64'(conv_busy), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst", 64'({disp_obs(), LEDR, conv_busy}), 64'({{6{7'h7F}}, 10'd0, 1'b0}));
        ch_data[31:24] = 8'd13;
        @(posedge clk);
        #1 resetn = 1'b1;
        push_exp("disp_after_rst", 75, 0);
        cyc();
        check("ledr_tc", 64'(LEDR), 64'({6'b001101, 4'b0000}));
        repeat (9) cyc();
        pop_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/display_pager.md
Name: display_pager

Overview:
- Clocked, parametrised successor to the combinational trading-status display.
- Shows one of N_CH monitored values at a time (buy price, sell price, spread, trade count, ...) as unsigned decimal on HEX3..HEX0, with the channel label on HEX5..HEX4.
- Pages through channels on a button pulse or a timer.
- Converts binary to BCD sequentially (shift-add-3). Stretches the match indication and blinks the display on halt.
- Sits between the matching-engine core and the board HEX/LEDR pins.

Parameters:
- DATA_W, 8, width of each channel value; legal range 4..13 (the maximum value must fit in 4 decimal digits).
- N_CH, 4, number of channels; legal range 1..16.
- PAGE_TICKS, 50_000_000, clk cycles per auto-page step.
- BLINK_TICKS, 25_000_000, clk cycles per half-period of the halt blink.
- MATCH_HOLD, 12_500_000, clk cycles LEDR[3] stays high after a match pulse.
- TC_CH, N_CH-1, channel whose low 6 bits drive LEDR[9:4].

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ch_data  in  N_CH*DATA_W  packed channel values; channel k occupies bits [k*DATA_W +: DATA_W].
- state  in  2  core FSM state.
- halt_signal  in  1  core halted (level).
- match_signal  in  1  match event; a pulse or level.
- page_next  in  1  synchronous one-cycle pulse (debounced upstream) that advances the page.
- auto_page  in  1  level; 1 enables timer paging.
- HEX0..HEX5  out  7 each  active-low segments; bit6=g ... bit0=a.
- LEDR  out  10  status LEDs.
- conv_busy  out  1  high while a BCD conversion is running.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - page=0; HEX0..5=7'h7F (blank); LEDR=0; conv_busy=0; all counters=0; FSM=LOAD.
- FSM states: LOAD, CONV, SHOW.
  - LOAD (1 cycle): capture sample=ch_data[page]; clear the BCD shift register; bit counter=DATA_W; go to CONV; conv_busy=1.
  - CONV (DATA_W cycles): each cycle, add 3 to every BCD nibble >=5, then shift left one bit, taking the next sample bit MSB-first. When the counter reaches 0, go to SHOW.
  - SHOW: write the digit registers; conv_busy=0.
    - If ch_data[page] != sample, or page changed, go to LOAD next cycle.
    - Otherwise hold.
- Latency: an input change seen in SHOW updates the HEX outputs DATA_W+2 cycles later.
- HEX digit registers hold their old value during LOAD/CONV, so the display never flickers.
- Input changes during CONV are not aborted. They are picked up by the SHOW comparison after completion.
- Digits:
  - HEX0 = ones, HEX1 = tens, HEX2 = hundreds, HEX3 = thousands.
  - Leading-zero blanking on HEX3..HEX1. HEX0 always lit, so value 0 shows "0".
- Label: HEX5 = lowercase 'c' (7'h27); HEX4 = page as a hex digit 0..F.
- Paging:
  - page_next advances page modulo N_CH; page N_CH-1 wraps to 0.
  - With auto_page=1, a tick counter advances the page when it reaches PAGE_TICKS-1, then clears.
  - page_next also clears the tick counter.
  - page_next and an auto tick in the same cycle give exactly one advance.
  - auto_page=0 holds the tick counter at 0.
  - A page change during CONV is applied immediately to page and HEX4; the digits refresh after the current conversion plus a new one.
- Halt blink:
  - While halt_signal=1, a blink counter toggles a phase every BLINK_TICKS. When phase=1, all HEX outputs are forced to 7'h7F; the digit registers are unaffected.
  - halt_signal=0 clears the counter and phase immediately, so the display is lit.
- LEDR:
  - [1:0] = state.
  - [2] = halt_signal.
  - [3] = match stretch: a rising edge of match_signal loads the hold counter with MATCH_HOLD-1; LEDR[3]=1 while the counter is nonzero or match_signal=1. A new edge while active reloads the counter.
  - [9:4] = ch_data[TC_CH][5:0]; for DATA_W<6, zero-extended.
  - All LEDR bits are registered (1-cycle delay).
- Counter widths: $clog2 of the respective parameter, minimum 1.

Decomposition:
- Shared package display_pkg:
  - segment constants: SEG_BLANK=7'h7F, SEG_C_LOWER=7'h27;
  - FSM state enum {LOAD, CONV, SHOW};
  - function bcd_digits(DATA_W) returning the digit count.
- Sub-module seg7_hex: combinational 4-bit to active-low 7-seg, 0..F.
  - Digit codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Instantiated 5 times: HEX0..HEX4.

Test Plan (bench overrides PAGE_TICKS=8, BLINK_TICKS=4, MATCH_HOLD=6):
- Reset, then ch0=50, ch1=60, ch2=10, ch3=0 -> within 10 cycles HEX3..0=7F,7F,12,40; HEX5=27; HEX4=40; LEDR=0.
- ch0 changes 50->75 in SHOW -> conv_busy high for 9 cycles; HEX1..0 become 78,12 exactly 10 cycles after the change; old digits stay held until then.
- Pulse page_next 4 times, each 12 cycles apart, auto_page=0 -> HEX4 shows 79, 24, 30, then wraps to 40; digits track 60, 10, 0 ("0" lit, HEX3..1 blank), then 75.
- auto_page=1 with page_next pulsed on the same cycle the tick counter hits 7 -> page advances by exactly 1; the next auto advance comes 8 cycles later.
- match_signal one-cycle pulse -> LEDR[3]=1 for 6 cycles starting 1 cycle later; a second pulse at cycle 3 extends it to cycle 9.
- halt_signal=1 -> HEX all 7F for 4 cycles, lit for 4, repeating; LEDR[2]=1. Assert resetn=0 mid-CONV -> all outputs reset immediately (asynchronous); ch3=13 after release -> LEDR[9:4]=6'b001101.
